// File: rtl/gate_dataflow.sv
// Registered five-input gate: y = ((a & b) | ~(c & d)) ^ e.
// Latency 1 clock, one result per clock; no backpressure (no handshake ports).
module gate_dataflow (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  input  logic i_e,
  output logic o_y
);

  logic f;

  assign f = ((i_a & i_b) | ~(i_c & i_d)) ^ i_e;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_y <= 1'b0;
    end else begin
      o_y <= f;
    end
  end

endmodule

// File: tb/tb_gate_dataflow.sv
// Scoreboard bench for gate_dataflow: the driver queues hand-computed results,
// and the monitor pops and compares one entry after every rising edge.
module tb_gate_dataflow;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic y;

  int checks = 0;
  int failures = 0;

  // Hand-derived truth table indexed by {e,d,c,b,a}: with e=0 the result is 0
  // only for indices 12..14 (c=d=1 without a=b=1); e=1 inverts that.
  localparam logic [31:0] TT = 32'h7000_8FFF;

  typedef struct {
    logic  exp;
    string tag;
  } sb_t;

  sb_t  exp_q[$];
  logic last_exp = 1'b0;
  bit   have_last = 1'b0;

  gate_dataflow dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_a  (a),
    .i_b  (b),
    .i_c  (c),
    .i_d  (d),
    .i_e  (e),
    .o_y  (y)
  );

  always #5 clk = ~clk;

  // Drive at the falling edge; the queued value is what o_y must hold after the next rising edge.
  task automatic step(input logic r, input logic [4:0] v, input string tag);
    logic [31:0] tt;
    sb_t s;
    @(negedge clk);
    tt = TT;
    rst = r;
    {e, d, c, b, a} = v;
    s.exp = r ? 1'b0 : tt[v];
    s.tag = tag;
    exp_q.push_back(s);
  endtask

  task automatic step_exp(input logic r, input logic [4:0] v, input logic x, input string tag);
    sb_t s;
    @(negedge clk);
    rst = r;
    {e, d, c, b, a} = v;
    s.exp = x;
    s.tag = tag;
    exp_q.push_back(s);
  endtask

  always @(posedge clk) begin
    sb_t s;
    #1;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      checks++;
      if (y !== s.exp) begin
        failures++;
        $display("FAIL %s: o_y=%b expected=%b", s.tag, y, s.exp);
      end
      last_exp = s.exp;
      have_last = 1'b1;
    end
  end

  // Inputs have just changed at the falling edge; o_y must still hold.
  always @(negedge clk) begin
    #1;
    if (have_last) begin
      checks++;
      if (y !== last_exp) begin
        failures++;
        $display("FAIL hold: o_y=%b expected=%b", y, last_exp);
      end
    end
  end

  initial begin
    int budget;
    // Reset with all inputs high, then held for three more edges.
    for (int i = 0; i < 4; i++) step_exp(1'b1, 5'd31, 1'b0, "reset");

    // Spot values with explicit expectations.
    step_exp(1'b0, 5'd0,  1'b1, "spot_all0");
    step_exp(1'b0, 5'd3,  1'b1, "spot_ab");
    step_exp(1'b0, 5'd12, 1'b0, "spot_cd");
    step_exp(1'b0, 5'd28, 1'b1, "spot_cde");
    step_exp(1'b0, 5'd31, 1'b0, "spot_all1");

    // Latency: f=1 then f=0 on consecutive edges.
    step_exp(1'b0, 5'd0,  1'b1, "lat_first");
    step_exp(1'b0, 5'd12, 1'b0, "lat_second");

    // Exhaustive sweep, each value held two cycles, with a one-edge reset at 10.
    for (int v = 0; v < 32; v++) begin
      if (v == 10) begin
        step(1'b1, 5'(v), "sweep_midreset");
        step(1'b0, 5'(v), "sweep_resume");
      end else begin
        step(1'b0, 5'(v), "sweep");
        step(1'b0, 5'(v), "sweep_hold");
      end
    end

    // Back-to-back: a=b=1 with e toggling every cycle.
    for (int i = 0; i < 6; i++)
      step_exp(1'b0, (i % 2 == 0) ? 5'd3 : 5'd19, (i % 2 == 0) ? 1'b1 : 1'b0, "toggle_e");

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_dataflow.md
GATE_DATAFLOW -- requirements
Module: gate_dataflow

Interface
REQ-001 Parameters: none; the logic function and reset value are fixed.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_a  input  1  gate operand A.
REQ-005 i_b  input  1  gate operand B.
REQ-006 i_c  input  1  gate operand C.
REQ-007 i_d  input  1  gate operand D.
REQ-008 i_e  input  1  gate operand E.
REQ-009 o_y  output  1  registered gate result.
REQ-010 No other ports: no handshake, no enable, no valid.

Function
REQ-011 Combinational term f SHALL be f = ((i_a AND i_b) OR NOT(i_c AND i_d)) XOR i_e.
REQ-012 Write f as continuous-assignment dataflow logic: no latches and no inferred memories.
REQ-013 On each rising i_clk edge with i_rst=0, o_y SHALL load f evaluated on the inputs sampled at that edge.
REQ-014 Latency from inputs to o_y SHALL be exactly 1 clock.
REQ-015 Throughput SHALL be 1 result per clock.
REQ-016 o_y SHALL hold its value between edges.
REQ-017 o_y SHALL not change combinationally with input changes between edges.
REQ-018 Inputs SHALL be treated as synchronous to i_clk.
REQ-019 Inputs changing every cycle or every N cycles SHALL produce the matching f one edge later.
REQ-020 The block has no state beyond the o_y register.

Reset
REQ-021 When i_rst=1 at a rising edge, o_y SHALL become 0 regardless of inputs.
REQ-022 Reset asserted while inputs toggle SHALL force o_y=0 at that edge; in-flight results are discarded.
REQ-023 On the first edge with i_rst=0 after reset, o_y SHALL load f of the inputs sampled at that edge.
REQ-024 Before the first reset edge o_y is undefined.
REQ-025 Benches SHALL apply reset for at least 1 cycle before checking o_y.

Verification
REQ-026 Reset: i_rst=1 with all inputs=1 -> o_y=0 after the edge; hold reset 3 cycles -> o_y stays 0.
REQ-027 Exhaustive sweep: 5-bit counter {e,d,c,b,a} stepped 0..31, each value held 2 cycles -> o_y matches f one edge later for every value. Spot values:
- a=b=c=d=e=0 -> 1
- a=b=1, c=d=e=0 -> 1
- c=d=1, a=b=e=0 -> 0
- c=d=e=1, a=b=0 -> 1
- all inputs 1 -> 0
REQ-028 Latency: change inputs from all 0 (f=1) to c=d=1, others 0 (f=0) -> o_y=1 at that edge and 0 at the next edge.
REQ-029 Mid-operation reset: during the sweep, assert i_rst for one edge -> o_y=0; on the next edge o_y resumes f of the current inputs.
REQ-030 Back-to-back: toggle i_e every cycle with a=b=1 -> o_y alternates 1,0,1,0 delayed by one cycle.
